adc_frame_sampler: RTL and testbench

Frame sequencer that sits directly downstream of the ADS8689 ADC controller in the tactile MEM_frame datapath. It walks the external analog mux across `CH_NUM` taxel channels and waits a settle time after each switch. For each channel it issues `2^AVG_LOG2` single-cycle `begin_conv` requests, captures `conv_data` on each `conv_done` pulse, and averages the results. It presents one averaged 16-bit word per channel on a valid/ready stream to the frame buffer.

---
 rtl/adc_frame_sampler_if.sv | 31 +++
 rtl/adc_frame_sampler.sv | 202 ++++++++++++++++++++
 tb/tb_adc_frame_sampler.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_frame_sampler_if.sv
// -----------------------------------------------------------------------------
// adc_frame_sampler_if
// Valid/ready stream carrying one averaged ADC word per taxel channel from the
// frame sampler to the frame buffer.
//   out_valid  master->slave  averaged sample available
//   out_ready  slave->master  downstream accepts when out_valid & out_ready
//   out_ch     master->slave  channel index of out_data (CH_W bits)
//   out_data   master->slave  averaged 16-bit sample
// -----------------------------------------------------------------------------
interface adc_frame_sampler_if #(
   parameter int CH_W = 4
) ();
   logic            out_valid;
   logic            out_ready;
   logic [CH_W-1:0] out_ch;
   logic [15:0]     out_data;

   modport master (
      output out_valid,
      output out_ch,
      output out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_ch,
      input  out_data,
      output out_ready
   );
endinterface

// File: rtl/adc_frame_sampler.sv
// -----------------------------------------------------------------------------
// adc_frame_sampler
// Walks the analog mux across CH_NUM taxel channels. After each mux change it
// waits SETTLE_CNT cycles, then requests 2^AVG_LOG2 conversions from the ADC
// controller, sums the results and emits the truncated mean per channel.
// Ports:
//   clk_50m, rst      clock; synchronous active-high reset
//   init_done         ADC controller configured; frames are only accepted then
//   frame_start       single-cycle request to sample one frame
//   conv_done/data    ADC result strobe and value (data valid only with strobe)
//   begin_conv        single-cycle conversion request
//   mux_sel           analog mux channel select
//   out_if            averaged sample stream (valid/ready, channel, data)
//   frame_done        pulse after the last channel of a frame is accepted
//   busy              high in every state except IDLE
//   timeout_err       sticky: a conversion timed out and the frame was aborted
//   overrun_err       sticky: frame_start arrived while a frame was running
// -----------------------------------------------------------------------------
module adc_frame_sampler #(
   parameter int CH_NUM      = 16,
   parameter int CH_W        = 4,
   parameter int AVG_LOG2    = 2,
   parameter int SETTLE_CNT  = 50,
   parameter int TIMEOUT_CNT = 4095
) (
   input  logic                clk_50m,
   input  logic                rst,
   input  logic                init_done,
   input  logic                frame_start,
   input  logic                conv_done,
   input  logic [15:0]         conv_data,
   output logic                begin_conv,
   output logic [CH_W-1:0]     mux_sel,
   adc_frame_sampler_if.master out_if,
   output logic                frame_done,
   output logic                busy,
   output logic                timeout_err,
   output logic                overrun_err
);

   localparam int ACC_W = 16 + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int SET_W = $clog2(SETTLE_CNT + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CNT + 1);

   localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(CH_NUM - 1);
   localparam logic [CNT_W-1:0] SAMPLES     = CNT_W'(1 << AVG_LOG2);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CNT - 1);
   localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CNT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_TRIG, S_WAIT, S_ACC, S_EMIT
   } state_e;

   state_e             state_q;
   logic [CH_W-1:0]    ch_q;
   logic [SET_W-1:0]   settle_cnt_q;
   logic [TO_W-1:0]    wait_cnt_q;
   logic [CNT_W-1:0]   samp_cnt_q;
   logic [ACC_W-1:0]   acc_q;
   logic [15:0]        sample_q;
   logic               begin_conv_q;
   logic               out_valid_q;
   logic [CH_W-1:0]    out_ch_q;
   logic [15:0]        out_data_q;
   logic               frame_done_q;
   logic               busy_q;
   logic               timeout_err_q;
   logic               overrun_err_q;

   // Accumulator is 16+AVG_LOG2 bits wide, so summing 2^AVG_LOG2 full-scale
   // samples can never wrap.
   logic [ACC_W-1:0]   acc_d;
   logic [CNT_W-1:0]   samp_cnt_d;

   assign acc_d      = acc_q + ACC_W'(sample_q);
   assign samp_cnt_d = samp_cnt_q + CNT_W'(1);

   // NOTE: every register below is assigned with <= so all state updates
   // see the pre-edge values, independent of statement order.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q       <= S_IDLE;
         ch_q          <= '0;
         settle_cnt_q  <= '0;
         wait_cnt_q    <= '0;
         samp_cnt_q    <= '0;
         acc_q         <= '0;
         sample_q      <= '0;
         begin_conv_q  <= 1'b0;
         out_valid_q   <= 1'b0;
         out_ch_q      <= '0;
         out_data_q    <= '0;
         frame_done_q  <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         // Single-cycle strobes default low.
         begin_conv_q <= 1'b0;
         frame_done_q <= 1'b0;

         if (frame_start && (state_q != S_IDLE)) begin
            overrun_err_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (frame_start && init_done) begin
                  ch_q          <= '0;
                  settle_cnt_q  <= '0;
                  samp_cnt_q    <= '0;
                  acc_q         <= '0;
                  timeout_err_q <= 1'b0;
                  overrun_err_q <= 1'b0;
                  busy_q        <= 1'b1;
                  state_q       <= S_SETTLE;
               end
            end

            S_SETTLE: begin
               if (settle_cnt_q == SETTLE_LAST) begin
                  begin_conv_q <= 1'b1;
                  state_q      <= S_TRIG;
               end else begin
                  settle_cnt_q <= settle_cnt_q + SET_W'(1);
               end
            end

            S_TRIG: begin
               // The trigger cycle itself counts towards the timeout.
               wait_cnt_q <= TO_W'(1);
               state_q    <= S_WAIT;
            end

            S_WAIT: begin
               if (conv_done) begin
                  sample_q <= conv_data;
                  state_q  <= S_ACC;
               end else if (wait_cnt_q >= TO_LAST) begin
                  timeout_err_q <= 1'b1;
                  ch_q          <= '0;
                  acc_q         <= '0;
                  samp_cnt_q    <= '0;
                  busy_q        <= 1'b0;
                  state_q       <= S_IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + TO_W'(1);
               end
            end

            S_ACC: begin
               acc_q      <= acc_d;
               samp_cnt_q <= samp_cnt_d;
               if (samp_cnt_d < SAMPLES) begin
                  // Same channel: retrigger without re-settling the mux.
                  begin_conv_q <= 1'b1;
                  state_q      <= S_TRIG;
               end else begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= acc_d[AVG_LOG2+15:AVG_LOG2];
                  out_ch_q    <= ch_q;
                  state_q     <= S_EMIT;
               end
            end

            S_EMIT: begin
               if (out_if.out_ready) begin
                  out_valid_q <= 1'b0;
                  acc_q       <= '0;
                  samp_cnt_q  <= '0;
                  if (ch_q == CH_LAST) begin
                     frame_done_q <= 1'b1;
                     ch_q         <= '0;
                     busy_q       <= 1'b0;
                     state_q      <= S_IDLE;
                  end else begin
                     ch_q         <= ch_q + CH_W'(1);
                     settle_cnt_q <= '0;
                     state_q      <= S_SETTLE;
                  end
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   // ch_q only moves on SETTLE entry and on return to IDLE, so it is the mux
   // select directly.
   assign mux_sel          = ch_q;
   assign begin_conv       = begin_conv_q;
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_ch    = out_ch_q;
   assign out_if.out_data  = out_data_q;
   assign frame_done       = frame_done_q;
   assign busy             = busy_q;
   assign timeout_err      = timeout_err_q;
   assign overrun_err      = overrun_err_q;

endmodule

// File: tb/tb_adc_frame_sampler.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_sampler
// Bench for adc_frame_sampler. A behavioural ADC model answers each begin_conv
// after a fixed latency with values from a per-frame table. Expected words are
// queued when a frame is started; a monitor pops and compares on each output
// handshake. A second small instance covers full-scale averaging with
// AVG_LOG2=4.
// -----------------------------------------------------------------------------
module tb_adc_frame_sampler;

   localparam int CH_NUM   = 4;
   localparam int CH_W     = 2;
   localparam int AVG_LOG2 = 2;
   localparam int SETTLE   = 50;
   localparam int TMO      = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance signals
   logic            rst, init_done, frame_start, conv_done;
   logic [15:0]     conv_data;
   logic            begin_conv, frame_done, busy, timeout_err, overrun_err;
   logic [CH_W-1:0] mux_sel;
   adc_frame_sampler_if #(.CH_W(CH_W)) out_if ();

   adc_frame_sampler #(
      .CH_NUM(CH_NUM), .CH_W(CH_W), .AVG_LOG2(AVG_LOG2),
      .SETTLE_CNT(SETTLE), .TIMEOUT_CNT(TMO)
   ) dut (
      .clk_50m(clk), .rst(rst), .init_done(init_done),
      .frame_start(frame_start), .conv_done(conv_done), .conv_data(conv_data),
      .begin_conv(begin_conv), .mux_sel(mux_sel), .out_if(out_if),
      .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err),
      .overrun_err(overrun_err)
   );

   // Second instance: 2 channels, 16 samples each, always ready
   logic        frame_start2, conv_done2;
   logic [15:0] conv_data2;
   logic        begin_conv2, frame_done2, busy2, timeout_err2, overrun_err2;
   logic [0:0]  mux_sel2;
   adc_frame_sampler_if #(.CH_W(1)) if2 ();
   assign if2.out_ready = 1'b1;

   adc_frame_sampler #(
      .CH_NUM(2), .CH_W(1), .AVG_LOG2(4), .SETTLE_CNT(2), .TIMEOUT_CNT(50)
   ) dut2 (
      .clk_50m(clk), .rst(rst), .init_done(init_done),
      .frame_start(frame_start2), .conv_done(conv_done2), .conv_data(conv_data2),
      .begin_conv(begin_conv2), .mux_sel(mux_sel2), .out_if(if2),
      .frame_done(frame_done2), .busy(busy2), .timeout_err(timeout_err2),
      .overrun_err(overrun_err2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic [15:0]     data;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] adc_vals[4];
   logic        adc_en;
   int          adc_idx  = 0;
   int          cyc      = 0;
   int          trig_cnt = 0;
   int          fd_cnt   = 0;
   int          exp_trig = -1;
   int          words2   = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ADC model for the main instance: result two cycles after begin_conv.
   initial begin
      conv_done = 1'b0;
      conv_data = 16'hDEAD;
      forever begin
         @(negedge clk);
         if (begin_conv && adc_en && !rst) begin
            repeat (2) @(posedge clk);
            #1;
            conv_done = 1'b1;
            conv_data = adc_vals[adc_idx % 4];
            adc_idx++;
            @(posedge clk);
            #1;
            conv_done = 1'b0;
            conv_data = 16'hDEAD;
         end
      end
   end

   // ADC model for the second instance: full-scale result one cycle later.
   initial begin
      conv_done2 = 1'b0;
      conv_data2 = 16'h0000;
      forever begin
         @(negedge clk);
         if (begin_conv2 && !rst) begin
            @(posedge clk);
            #1;
            conv_done2 = 1'b1;
            conv_data2 = 16'hFFFF;
            @(posedge clk);
            #1;
            conv_done2 = 1'b0;
            conv_data2 = 16'h0000;
         end
      end
   end

   // Monitor: scoreboard pops, trigger/frame_done counting, settle spacing.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (begin_conv) begin
            trig_cnt++;
            check("no_trig_while_valid", 32'(out_if.out_valid), 32'd0);
            if (exp_trig >= 0) begin
               check("settle_gap_cycle", 32'(cyc), 32'(exp_trig));
               exp_trig = -1;
            end
         end
         if (frame_done) fd_cnt++;
         if (out_if.out_valid && out_if.out_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_pending_words", 32'(sb_q.size()), 32'd1);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("out_ch", 32'(out_if.out_ch), 32'(e.ch));
               check("out_data", 32'(out_if.out_data), 32'(e.data));
               check("mux_sel_at_emit", 32'(mux_sel), 32'(e.ch));
               if (e.ch != CH_W'(CH_NUM - 1)) exp_trig = cyc + 1 + SETTLE;
            end
         end
      end
      if (if2.out_valid && !rst) begin
         words2++;
         check("dut2_out_data", 32'(if2.out_data), 32'h0000FFFF);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vals(input logic [15:0] a, b, c, d, input logic [15:0] avg, input bit push);
      adc_vals[0] = a; adc_vals[1] = b; adc_vals[2] = c; adc_vals[3] = d;
      if (push) begin
         for (int i = 0; i < CH_NUM; i++) sb_q.push_back('{ch: CH_W'(i), data: avg});
      end
   endtask

   // Called at #1 after an edge; returns one cycle after acceptance.
   task automatic start_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic wait_frame_done(input string name, input int max_cyc);
      int n = 0;
      do begin
         tick();
         n++;
      end while (frame_done !== 1'b1 && n < max_cyc);
      check(name, 32'(frame_done), 32'd1);
   endtask

   task automatic wait_trig(input string name, input int max_cyc);
      int n = 0;
      do begin
         tick();
         n++;
      end while (begin_conv !== 1'b1 && n < max_cyc);
      check(name, 32'(begin_conv), 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_begin_conv"},  32'(begin_conv),       32'd0);
      check({tag, "_mux_sel"},     32'(mux_sel),          32'd0);
      check({tag, "_out_valid"},   32'(out_if.out_valid), 32'd0);
      check({tag, "_out_ch"},      32'(out_if.out_ch),    32'd0);
      check({tag, "_out_data"},    32'(out_if.out_data),  32'd0);
      check({tag, "_frame_done"},  32'(frame_done),       32'd0);
      check({tag, "_busy"},        32'(busy),             32'd0);
      check({tag, "_timeout_err"}, 32'(timeout_err),      32'd0);
      check({tag, "_overrun_err"}, 32'(overrun_err),      32'd0);
   endtask

   initial begin
      int t0, f0;
      bit found;
      rst          = 1'b1;
      init_done    = 1'b0;
      frame_start  = 1'b0;
      frame_start2 = 1'b0;
      adc_en       = 1'b1;
      out_if.out_ready = 1'b1;
      set_vals(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      tick();

      // frame_start without init_done is ignored
      start_frame();
      check("no_init_busy", 32'(busy), 32'd0);
      check("no_init_overrun", 32'(overrun_err), 32'd0);
      init_done = 1'b1;
      repeat (3) tick();

      // Frame A: 100..103 -> 101 on every channel; first-trigger timing
      set_vals(16'd100, 16'd101, 16'd102, 16'd103, 16'd101, 1'b1);
      t0 = trig_cnt;
      f0 = fd_cnt;
      start_frame();
      check("a_busy", 32'(busy), 32'd1);
      check("a_mux_sel", 32'(mux_sel), 32'd0);
      repeat (SETTLE - 1) tick();
      check("a_no_early_trig", 32'(begin_conv), 32'd0);
      tick();
      check("a_first_trig", 32'(begin_conv), 32'd1);
      wait_frame_done("a_frame_done", 2000);
      tick();
      check("a_frame_done_pulse", 32'(frame_done), 32'd0);
      check("a_busy_after", 32'(busy), 32'd0);
      check("a_trig_count", 32'(trig_cnt - t0), 32'd16);
      check("a_frame_done_count", 32'(fd_cnt - f0), 32'd1);
      check("a_sb_drained", 32'(sb_q.size()), 32'd0);

      // Frame B: 1000,2000,3000,4001 -> 2500; overrun mid-frame, stall on ch1
      set_vals(16'd1000, 16'd2000, 16'd3000, 16'd4001, 16'd2500, 1'b1);
      start_frame();
      repeat (10) tick();
      start_frame();
      check("b_overrun", 32'(overrun_err), 32'd1);
      check("b_busy", 32'(busy), 32'd1);
      found = 1'b0;
      for (int n = 0; n < 2000 && !found; n++) begin
         tick();
         if (out_if.out_valid && out_if.out_ch == CH_W'(1)) found = 1'b1;
      end
      check("b_reach_ch1", 32'(found), 32'd1);
      out_if.out_ready = 1'b0;
      t0 = trig_cnt;
      for (int n = 0; n < 20; n++) begin
         tick();
         check("stall_valid", 32'(out_if.out_valid), 32'd1);
         check("stall_ch", 32'(out_if.out_ch), 32'd1);
         check("stall_data", 32'(out_if.out_data), 32'd2500);
      end
      @(negedge clk);
      check("stall_no_trig", 32'(trig_cnt - t0), 32'd0);
      tick();
      out_if.out_ready = 1'b1;
      wait_frame_done("b_frame_done", 2000);
      check("b_overrun_sticky", 32'(overrun_err), 32'd1);

      // Frame C: accepted in the frame_done cycle; full-scale, no wrap
      set_vals(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
      start_frame();
      check("c_back_to_back_busy", 32'(busy), 32'd1);
      check("c_overrun_cleared", 32'(overrun_err), 32'd0);
      wait_frame_done("c_frame_done", 2000);
      tick();
      check("c_sb_drained", 32'(sb_q.size()), 32'd0);

      // Timeout: ADC never answers
      adc_en = 1'b0;
      f0 = fd_cnt;
      start_frame();
      wait_trig("tmo_trig", 200);
      repeat (TMO - 1) tick();
      check("tmo_not_yet", 32'(timeout_err), 32'd0);
      check("tmo_busy_before", 32'(busy), 32'd1);
      tick();
      check("tmo_err", 32'(timeout_err), 32'd1);
      check("tmo_busy", 32'(busy), 32'd0);
      check("tmo_mux_sel", 32'(mux_sel), 32'd0);
      repeat (5) tick();
      check("tmo_no_frame_done", 32'(fd_cnt - f0), 32'd0);
      check("tmo_err_sticky", 32'(timeout_err), 32'd1);

      // Frame D: new frame clears timeout_err; 0,0,0,3 -> 0
      adc_en = 1'b1;
      set_vals(16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 1'b1);
      start_frame();
      check("d_timeout_cleared", 32'(timeout_err), 32'd0);
      wait_frame_done("d_frame_done", 2000);
      tick();

      // Reset while in WAIT
      adc_en = 1'b0;
      f0 = fd_cnt;
      start_frame();
      wait_trig("rst_trig", 200);
      repeat (5) tick();
      start_frame();
      check("rst_overrun_before", 32'(overrun_err), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_outputs_zero("rst_mid");
      repeat (5) tick();
      check("rst_stays_idle", 32'(busy), 32'd0);
      check("rst_no_frame_done", 32'(fd_cnt - f0), 32'd0);

      // Second instance: 16 x 0xFFFF averages to 0xFFFF on both channels
      frame_start2 = 1'b1;
      tick();
      frame_start2 = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 1000 && !found; n++) begin
         tick();
         if (frame_done2) found = 1'b1;
      end
      check("dut2_frame_done", 32'(found), 32'd1);
      tick();
      check("dut2_word_count", 32'(words2), 32'd2);

      check("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
